// File: rtl/boron_key_pkg.sv
// Shared constants, S-box tables and FSM encoding for the BORON inverse key schedule.
package boron_key_pkg;

    // Number of forward key-update steps and the key-rotation amount.
    localparam int unsigned ROUNDS_DEFAULT = 25;
    localparam int unsigned ROT            = 61;

    // The round index is XORed into this 5-bit field of the key.
    localparam int unsigned IDX_LO = 62;
    localparam int unsigned IDX_HI = 66;

    // Entry x of each table is stored in nibble x of the 64-bit constant.
    // Forward: E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6
    localparam logic [63:0] SBOX_FWD = 64'h6358_F02D_AC97_1B4E;
    // Inverse: A,3,9,E,1,D,F,4,C,5,7,2,6,8,0,B
    localparam logic [63:0] SBOX_INV = 64'hB086_275C_4FD1_E93A;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFwd  = 2'd1,
        StOut  = 2'd2
    } state_e;

    // Look up the forward S-box.
    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        return SBOX_FWD[{x, 2'b00} +: 4];
    endfunction

    // Look up the inverse S-box.
    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        return SBOX_INV[{x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/boronSbox.sv
// BORON forward 4-bit S-box, purely combinational.
module boronSbox (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Table lookup, written out so it reads directly against the cipher definition.
    always_comb begin
        dout = 4'h0;
        unique case (din)
            4'h0: dout = 4'hE;
            4'h1: dout = 4'h4;
            4'h2: dout = 4'hB;
            4'h3: dout = 4'h1;
            4'h4: dout = 4'h7;
            4'h5: dout = 4'h9;
            4'h6: dout = 4'hC;
            4'h7: dout = 4'hA;
            4'h8: dout = 4'hD;
            4'h9: dout = 4'h2;
            4'hA: dout = 4'h0;
            4'hB: dout = 4'hF;
            4'hC: dout = 4'h8;
            4'hD: dout = 4'h5;
            4'hE: dout = 4'h3;
            4'hF: dout = 4'h6;
            default: dout = 4'h0;
        endcase
    end

endmodule

// File: rtl/boron_sbox_inv.sv
// BORON inverse 4-bit S-box, purely combinational.
module boron_sbox_inv
    import boron_key_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Table lookup from the packed inverse table.
    always_comb begin
        dout = sbox_inv(din);
    end

endmodule

// File: rtl/boron_key_schedule_inv.sv
// BORON 128-bit key schedule producing round keys in decryption order (RK_ROUNDS .. RK_0).
// The forward pass rolls the master key up to K_ROUNDS; the output pass walks it back down
// with the inverse step, one round key per handshake.
module boron_key_schedule_inv
    import boron_key_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_DEFAULT,
    parameter int unsigned KEY_W  = 128,
    parameter int unsigned RK_W   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_is_last,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [RK_W-1:0]  rk_data,
    output logic [4:0]       rk_idx,
    output logic             busy,
    output logic             done
);

    // The round index must fit the 5-bit field it is XORed into.
    if (ROUNDS > 31) begin : g_rounds_check
        $error("boron_key_schedule_inv: ROUNDS must be <= 31");
    end

    localparam logic [4:0] ROUNDS_L = 5'(ROUNDS);

    state_e           state_q;
    logic [KEY_W-1:0] key_q;
    logic [4:0]       cnt_q;
    logic             rk_valid_q;
    logic             busy_q;
    logic             done_q;

    // ---------------------------------------------------------------------------------------
    // Forward step F(K, cnt): rotate left by ROT, S-box the top two nibbles, XOR the index.
    // ---------------------------------------------------------------------------------------
    logic [KEY_W-1:0] rot_l;
    logic [3:0]       f_hi;
    logic [3:0]       f_lo;
    logic [KEY_W-1:0] fwd_key;

    assign rot_l = {key_q[KEY_W-1-ROT:0], key_q[KEY_W-1:KEY_W-ROT]};

    boronSbox u_sbox_f_hi (
        .din  (rot_l[KEY_W-1:KEY_W-4]),
        .dout (f_hi)
    );

    boronSbox u_sbox_f_lo (
        .din  (rot_l[KEY_W-5:KEY_W-8]),
        .dout (f_lo)
    );

    // Reassemble the forward-stepped key around the substituted nibbles and index field.
    always_comb begin
        fwd_key                = rot_l;
        fwd_key[KEY_W-1:KEY_W-4] = f_hi;
        fwd_key[KEY_W-5:KEY_W-8] = f_lo;
        fwd_key[IDX_HI:IDX_LO]   = rot_l[IDX_HI:IDX_LO] ^ cnt_q;
    end

    // ---------------------------------------------------------------------------------------
    // Inverse step G(K, cnt): undo the index XOR, inverse S-box the top nibbles, rotate right.
    // ---------------------------------------------------------------------------------------
    logic [3:0]       g_hi;
    logic [3:0]       g_lo;
    logic [KEY_W-1:0] inv_pre;
    logic [KEY_W-1:0] inv_key;

    boron_sbox_inv u_sbox_g_hi (
        .din  (key_q[KEY_W-1:KEY_W-4]),
        .dout (g_hi)
    );

    boron_sbox_inv u_sbox_g_lo (
        .din  (key_q[KEY_W-5:KEY_W-8]),
        .dout (g_lo)
    );

    // Build T, then rotate it right by ROT to recover the previous-round key.
    always_comb begin
        inv_pre                  = key_q;
        inv_pre[KEY_W-1:KEY_W-4] = g_hi;
        inv_pre[KEY_W-5:KEY_W-8] = g_lo;
        inv_pre[IDX_HI:IDX_LO]   = key_q[IDX_HI:IDX_LO] ^ cnt_q;
        inv_key                  = {inv_pre[ROT-1:0], inv_pre[KEY_W-1:ROT]};
    end

    // ---------------------------------------------------------------------------------------
    // Control FSM with registered outputs. Outputs never depend combinationally on rk_ready.
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            key_q      <= '0;
            cnt_q      <= '0;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A start coinciding with the done pulse belongs to the finished run.
                    if (start && !done_q) begin
                        key_q  <= key_in;
                        busy_q <= 1'b1;
                        if (key_is_last) begin
                            cnt_q      <= ROUNDS_L;
                            rk_valid_q <= 1'b1;
                            state_q    <= StOut;
                        end else begin
                            cnt_q   <= 5'd1;
                            state_q <= StFwd;
                        end
                    end
                end
                StFwd: begin
                    key_q <= fwd_key;
                    if (cnt_q == ROUNDS_L) begin
                        rk_valid_q <= 1'b1;
                        state_q    <= StOut;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                StOut: begin
                    if (rk_valid_q && rk_ready) begin
                        if (cnt_q == 5'd0) begin
                            rk_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            key_q <= inv_key;
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rk_valid = rk_valid_q;
    assign rk_data  = key_q[RK_W-1:0];
    assign rk_idx   = cnt_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_boron_key_schedule_inv.sv
// Directed bench for boron_key_schedule_inv: reference forward-schedule model, latency,
// ordering, backpressure, ignored starts and mid-run reset.
module tb_boron_key_schedule_inv;

    localparam int ROUNDS = 25;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         key_is_last;
    logic         rk_valid;
    logic         rk_ready;
    logic [63:0]  rk_data;
    logic [4:0]   rk_idx;
    logic         busy;
    logic         done;

    int n_checks;
    int n_fail;

    logic [63:0]  rk_exp [0:ROUNDS];
    logic [63:0]  obs_rk [0:ROUNDS];
    logic [127:0] k_last;

    boron_key_schedule_inv dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .key_in      (key_in),
        .key_is_last (key_is_last),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk_data     (rk_data),
        .rk_idx      (rk_idx),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [3:0] m_sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hE;  4'h1: return 4'h4;  4'h2: return 4'hB;  4'h3: return 4'h1;
            4'h4: return 4'h7;  4'h5: return 4'h9;  4'h6: return 4'hC;  4'h7: return 4'hA;
            4'h8: return 4'hD;  4'h9: return 4'h2;  4'hA: return 4'h0;  4'hB: return 4'hF;
            4'hC: return 4'h8;  4'hD: return 4'h5;  4'hE: return 4'h3;  default: return 4'h6;
        endcase
    endfunction

    function automatic logic [127:0] m_fwd(input logic [127:0] k, input logic [4:0] i);
        logic [127:0] s;
        s = {k[66:0], k[127:67]};
        s[127:124] = m_sbox(s[127:124]);
        s[123:120] = m_sbox(s[123:120]);
        s[66:62]   = s[66:62] ^ i;
        return s;
    endfunction

    task automatic build_model(input logic [127:0] k0);
        logic [127:0] k;
        k = k0;
        rk_exp[0] = k[63:0];
        for (int i = 1; i <= ROUNDS; i++) begin
            k = m_fwd(k, 5'(i));
            rk_exp[i] = k[63:0];
        end
        k_last = k;
    endtask

    // rdy_mode: 0 = always ready, 1 = random, 2 = random with a 10-cycle stall at idx 13.
    // poke: pulse a bogus start in FWD, in OUT and in the done cycle.
    task automatic run_and_check(input logic [127:0] key, input logic is_last,
                                 input int rdy_mode, input logic poke);
        int   e;
        int   exp_lat;
        int   exp_idx;
        int   stall;
        int   budget;
        logic got_valid;
        logic rdy;
        logic poked;
        build_model(key);
        key_in      = is_last ? k_last : key;
        key_is_last = is_last;
        start       = 1'b1;
        rk_ready    = 1'b0;
        got_valid   = 1'b0;
        e = 0;
        while (e < 40 && !got_valid) begin
            e++;
            @(negedge clk);
            start = 1'b0;
            if (rk_valid) begin
                got_valid = 1'b1;
            end else if (poke && e == 5) begin
                start = 1'b1; key_in = ~key; key_is_last = 1'b1;
            end
        end
        exp_lat = is_last ? 1 : ROUNDS + 1;
        n_checks++;
        if (!got_valid || e != exp_lat) begin
            n_fail++;
            $display("FAIL latency: got_valid=%0b edges=%0d expected %0d", got_valid, e, exp_lat);
            return;
        end
        exp_idx = ROUNDS; stall = 0; budget = 0; poked = 1'b0;
        while (exp_idx >= 0 && budget < 400) begin
            budget++;
            start = 1'b0;
            n_checks++;
            if (rk_valid !== 1'b1 || rk_idx !== 5'(exp_idx) || rk_data !== rk_exp[exp_idx]
                || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL rk_out: valid=%0b idx=%0d data=%h busy=%0b done=%0b expected idx=%0d data=%h",
                         rk_valid, rk_idx, rk_data, busy, done, exp_idx, rk_exp[exp_idx]);
            end
            obs_rk[exp_idx] = rk_data;
            if (rdy_mode == 0) rdy = 1'b1;
            else if (rdy_mode == 2 && exp_idx == 13 && stall < 10) begin
                rdy = 1'b0; stall++;
            end else rdy = 1'($urandom_range(0, 1));
            if (poke && !poked && exp_idx == 20) begin
                start = 1'b1; key_in = ~key; key_is_last = 1'b0; poked = 1'b1;
            end
            rk_ready = rdy;
            @(negedge clk);
            if (rdy) exp_idx--;
        end
        if (exp_idx >= 0) begin
            n_checks++; n_fail++;
            $display("FAIL handshake_timeout: stuck at idx %0d", exp_idx);
        end
        rk_ready = 1'b0;
        start    = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%0b busy=%0b valid=%0b expected 1 0 0", done, busy, rk_valid);
        end
        if (poke) begin
            start = 1'b1; key_in = ~key; key_is_last = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: done=%0b busy=%0b valid=%0b expected 0 0 0", done, busy, rk_valid);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if (rk_valid !== 1'b0 || rk_data !== 64'h0 || rk_idx !== 5'd0 || busy !== 1'b0
            || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: valid=%0b data=%h idx=%0d busy=%0b done=%0b expected all zero",
                     name, rk_valid, rk_data, rk_idx, busy, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; key_in = '0; key_is_last = 1'b0; rk_ready = 1'b0;
        #1;
        check_all_zero("reset_state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_zero_key();
        run_and_check(128'h0, 1'b0, 0, 1'b0);
        // Hand-derived keys for K_0 = 0.
        n_checks++;
        if (obs_rk[0] !== 64'h0) begin
            n_fail++; $display("FAIL zero_rk0: got %h expected %h", obs_rk[0], 64'h0);
        end
        n_checks++;
        if (obs_rk[1] !== 64'h4000_0000_0000_0000) begin
            n_fail++; $display("FAIL zero_rk1: got %h expected 4000000000000000", obs_rk[1]);
        end
        n_checks++;
        if (obs_rk[2] !== 64'h9DC0_0000_0000_0000) begin
            n_fail++; $display("FAIL zero_rk2: got %h expected 9dc0000000000000", obs_rk[2]);
        end
    endtask

    task automatic test_random_keys();
        for (int n = 0; n < 50; n++)
            run_and_check({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 1'b0);
    endtask

    task automatic test_key_is_last();
        run_and_check(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1, 0, 1'b0);
        for (int n = 0; n < 8; n++)
            run_and_check({$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_and_check(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b0, 2, 1'b0);
        for (int n = 0; n < 4; n++)
            run_and_check({$urandom, $urandom, $urandom, $urandom}, n[0], 1 + n[1], 1'b0);
    endtask

    task automatic test_back_to_back();
        run_and_check(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 1'b0, 0, 1'b1);
        // Issued on the cycle right after done.
        run_and_check(128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 0, 1'b1);
        run_and_check(128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0, 1'b1, 1, 1'b1);
    endtask

    task automatic test_reset_mid();
        int guard;
        key_in = 128'hCAFE_F00D_0000_0000_1234_5678_9ABC_DEF0; key_is_last = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_fwd");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset_fwd");
        build_model(128'h0BAD_C0DE_0000_FFFF_1357_9BDF_2468_ACE0);
        key_in = k_last; key_is_last = 1'b1; start = 1'b1; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (rk_idx !== 5'd12 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (rk_idx !== 5'd12 || rk_data !== rk_exp[12]) begin
            n_fail++;
            $display("FAIL reach_idx12: idx=%0d data=%h expected 12 %h", rk_idx, rk_data, rk_exp[12]);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_out");
        rk_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("after_reset_out");
        run_and_check(128'h0BAD_C0DE_0000_FFFF_1357_9BDF_2468_ACE0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_zero_key();
        test_random_keys();
        test_key_is_last();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/boron_key_schedule_inv.md
Name: boron_key_schedule_inv

Overview:
- Inverse (decryption-order) round-key generator for BORON with the 128-bit PRESENT-style key schedule.
- Forward step F(K,i), used with i = 1..ROUNDS:
  - S = K rotated left by 61, i.e. {K[66:0], K[127:67]}.
  - S[127:124] and S[123:120] each pass through the BORON S-box.
  - S[66:62] ^= i.
- The block accepts the master key or the last-round key and emits round keys RK_ROUNDS down to RK_0, where RK_i = K_i[63:0], over a valid/ready stream.
- It sits between the key register and the BORON decryption datapath.

Parameters:
- ROUNDS, 25: number of forward key-update steps; round keys are indexed 0..ROUNDS; must be ≤ 31.
- KEY_W, 128: key register width; fixed, present for documentation only.
- RK_W, 64: round-key width, taken from K[RK_W-1:0].

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- key_in  in  128  master key K_0, or K_ROUNDS when key_is_last=1; sampled with start.
- key_is_last  in  1  1 = key_in is already K_ROUNDS, so the forward pass is skipped; sampled with start.
- rk_valid  out  1  round key available.
- rk_ready  in  1  consumer accepts the key when rk_valid && rk_ready.
- rk_data  out  64  current round key.
- rk_idx  out  5  index i of rk_data.
- busy  out  1  high in FWD and OUT states.
- done  out  1  one-cycle pulse after RK_0 is accepted.

Behaviour:
- Reset (async assert, sync release): state=IDLE, K=0, cnt=0.
  - Outputs at reset: rk_valid=0, rk_data=0, rk_idx=0, busy=0, done=0.
- State IDLE:
  - If start: K<=key_in.
  - If key_is_last=0: cnt<=1, go to FWD.
  - If key_is_last=1: cnt<=ROUNDS, go to OUT.
- State FWD, one step per cycle:
  - K<=F(K,cnt).
  - If cnt==ROUNDS: go to OUT, leaving cnt=ROUNDS. Otherwise cnt<=cnt+1.
  - Exactly ROUNDS cycles in FWD.
  - rk_valid is first high ROUNDS+1 edges after the start edge; 1 edge after when key_is_last=1.
- State OUT:
  - rk_valid=1, rk_data=K[63:0], rk_idx=cnt; all driven straight from registers, no combinational path from rk_ready.
  - On handshake with cnt==0: go to IDLE, done=1 for the next cycle.
  - On handshake with cnt>0: K<=G(K,cnt), cnt<=cnt-1.
  - With no handshake, K, cnt and all outputs hold stable; valid must not drop without a handshake.
- Inverse step G(K,i):
  - T = K with T[66:62] = K[66:62] ^ i.
  - T[127:124] and T[123:120] each pass through the inverse S-box.
  - Result = T rotated right by 61, i.e. {T[60:0], T[127:61]}.
  - G(F(K,i),i) == K for every K and every i.
- Count arithmetic: the 5-bit index is XORed into bits [66:62]; there is no index 0 XOR in the forward direction.
- Throughput: one round key per cycle when rk_ready is held high; ROUNDS+1 keys total.
- start while busy=1 is ignored, including in the cycle done is asserted. start is accepted again from the cycle after return to IDLE.
- busy=0 and rk_valid=0 in IDLE.
- Reset mid-FWD or mid-OUT: immediate return to the reset state; no done pulse. Partial output is discarded by the consumer.

Decomposition:
- Package boron_key_pkg holds:
  - ROUNDS_DEFAULT = 25 and ROT = 61.
  - The forward S-box table: E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6.
  - The inverse table: A,3,9,E,1,D,F,4,C,5,7,2,6,8,0,B.
  - State encoding IDLE/FWD/OUT.
- Sub-modules:
  - boron_sbox_inv: new sub-module, 4-bit combinational, two instances for G.
  - Forward path reuses the existing boronSbox, two instances for F.

Test Plan:
1. key_in=0, key_is_last=0, rk_ready=1 -> rk_valid rises 26 edges after start; 26 handshakes with rk_idx 25,24,…,0; final rk_data=64'h0; done pulses once; busy falls.
2. Random 50 keys -> each rk_data/rk_idx pair equals a software forward-schedule model run to round i; RK_0 == key_in[63:0].
3. Take K_25 from the model, start with key_is_last=1 -> identical RK sequence to scenario 2; first rk_valid 1 edge after start.
4. rk_ready toggled randomly, including a 10-cycle stall at idx 13 -> rk_data/rk_idx stable during the stall; no key skipped or duplicated.
5. start pulsed during FWD and OUT -> ignored; sequence unchanged. A second start the cycle after done -> new run begins.
6. rst_n low at FWD cnt=7, and again at OUT idx=12 -> all outputs 0 immediately; no done pulse; a fresh start afterwards produces a correct full sequence.
